// File: rtl/mem_dump_controller.sv
// rtl/mem_dump_controller.sv - streams a range of data_memory words out of port B as LSB-first bytes
// A word is fetched in one cycle and then shifted out over a valid/ready byte interface.
module mem_dump_controller #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [31:0]   start_addr_i,
  input  logic [AW:0]   word_count_i,
  output logic [31:0]   mem_addr_o,
  input  logic [31:0]   mem_data_i,
  output logic          tx_valid_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_ready_i,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  localparam logic [AW:0] ONE_W = (AW+1)'(1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_word_idx;
  logic [AW:0]   r_words_left;
  logic [31:0]   r_shreg;
  logic [1:0]    r_byte_cnt;

  logic w_xfer;
  logic w_last_byte;
  logic w_more;
  logic w_unused_addr;

  // tx_ready_i only steers next-state/datapath updates, never an output
  assign w_xfer        = (r_state == S_SEND) && tx_ready_i;
  assign w_last_byte   = w_xfer && (r_byte_cnt == 2'd3);
  assign w_more        = r_words_left > ONE_W;
  assign w_unused_addr = ^{start_addr_i[31:AW+2], start_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = (word_count_i == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND:  if (w_last_byte) w_next = w_more ? S_FETCH : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word_idx   <= '0;
      r_words_left <= '0;
      r_shreg      <= '0;
      r_byte_cnt   <= '0;
    end else if (!abort_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i && (word_count_i != '0)) begin
            r_word_idx   <= start_addr_i[AW+1:2];
            r_words_left <= word_count_i;
          end
        end
        S_FETCH: begin
          r_shreg    <= mem_data_i;
          r_byte_cnt <= 2'd0;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shreg    <= {8'h00, r_shreg[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // word_idx wraps naturally at DEPTH because it is exactly AW bits
            if (w_last_byte && w_more) begin
              r_words_left <= r_words_left - ONE_W;
              r_word_idx   <= r_word_idx + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o = {{(30-AW){1'b0}}, r_word_idx, 2'b00};
  assign tx_valid_o = (r_state == S_SEND);
  assign tx_data_o  = r_shreg[7:0];
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_dump_controller.sv
// tb/tb_mem_dump_controller.sv - directed + randomized checks of mem_dump_controller against a queue model
module tb_mem_dump_controller;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [31:0]   start_addr_i = '0;
  logic [AW:0]   word_count_i = '0;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_data_i;
  logic          tx_valid_o;
  logic [7:0]    tx_data_o;
  logic          tx_ready_i = 1'b1;
  logic          busy_o;
  logic          done_o;

  mem_dump_controller #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .start_addr_i(start_addr_i), .word_count_i(word_count_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [DEPTH];
  assign mem_data_i = mem[mem_addr_o[AW+1:2]];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit rdy_rand = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_addr_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ready pattern: always high, or roughly 30% duty
  initial begin
    forever begin
      @(posedge clk_i); #1;
      tx_ready_i = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // sink-side monitor: transfers, done pulses, fetch addresses, stall stability
  always @(negedge clk_i) begin
    if (prev_stall) begin
      chk("stall_valid", 32'(tx_valid_o), 1);
      chk("stall_data", 32'(tx_data_o), 32'(prev_data));
    end
    prev_stall = tx_valid_o && !tx_ready_i && !abort_i && !rst_i;
    prev_data  = tx_data_o;
    if (!rst_i) begin
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
      if (done_o) done_cnt++;
      if (busy_o && !tx_valid_o && !done_o) addr_q.push_back(mem_addr_o);
    end
  end

  task automatic run_dump(input int sw, input int cnt, input bit rr, input bit repulse);
    int e0;
    int budget;
    logic [31:0] word;
    rdy_rand = rr;
    exp_q.delete(); exp_addr_q.delete(); got_q.delete(); addr_q.delete();
    done_cnt = 0;
    for (int w = 0; w < cnt; w++) begin
      word = mem[(sw + w) % DEPTH];
      exp_addr_q.push_back(32'(((sw + w) % DEPTH) * 4));
      for (int b = 0; b < 4; b++) exp_q.push_back(word[8*b +: 8]);
    end
    start_addr_i = ($urandom() & ~(32'(DEPTH - 1) << 2)) | (32'(sw) << 2);
    word_count_i = cnt[AW:0];
    start_i = 1'b1;
    e0 = cyc + 1;
    budget = 40 * cnt + 50;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_i); #1;
      if (k == 0) start_i = 1'b0;
      if (repulse && k == 6) begin
        start_i = 1'b1;
        start_addr_i = $urandom();
        word_count_i = (AW+1)'($urandom_range(1, DEPTH));
      end
      if (repulse && k == 7) start_i = 1'b0;
      if (done_o) break;
    end
    chk("done_seen", 32'(done_o), 1);
    if (!rr) chk("latency", cyc - e0, 5 * cnt);
    chk("busy_in_done", 32'(busy_o), 1);
    @(posedge clk_i); #1;
    chk("busy_fall", 32'(busy_o), 0);
    chk("done_width", 32'(done_o), 0);
    @(posedge clk_i); #1;
    chk("nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("byte", 32'(got_q[i]), 32'(exp_q[i]));
    chk("done_cnt", done_cnt, 1);
    chk("naddr", addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
      chk("addr", addr_q[i], exp_addr_q[i]);
  endtask

  initial begin
    int sw;
    logic [31:0] aw;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_valid", 32'(tx_valid_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    mem[2] = 32'hDEADBEEF;
    run_dump(2, 1, 1'b0, 1'b0);

    mem[255] = 32'h04030201;
    mem[0]   = 32'h08070605;
    run_dump(255, 2, 1'b0, 1'b0);

    run_dump($urandom_range(0, DEPTH - 1), 3, 1'b1, 1'b0);
    run_dump($urandom_range(0, DEPTH - 1), 0, 1'b0, 1'b0);
    run_dump($urandom_range(0, DEPTH - 1), 3, 1'b0, 1'b1);

    // start and abort together in IDLE
    start_i = 1'b1; abort_i = 1'b1; word_count_i = (AW+1)'(4);
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    chk("idle_abort_busy", 32'(busy_o), 0);
    chk("idle_abort_valid", 32'(tx_valid_o), 0);
    @(posedge clk_i); #1;
    chk("idle_abort_busy2", 32'(busy_o), 0);

    // abort during the second byte of a 4-word dump
    rdy_rand = 1'b0;
    got_q.delete(); addr_q.delete(); done_cnt = 0;
    sw = $urandom_range(0, DEPTH - 1);
    aw = mem[sw];
    start_addr_i = 32'(sw) << 2; word_count_i = (AW+1)'(4); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 50 && got_q.size() < 1; k++) begin
      @(posedge clk_i); #1;
    end
    chk("abort_sync", got_q.size(), 1);
    chk("abort_pre_valid", 32'(tx_valid_o), 1);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("abort_valid", 32'(tx_valid_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_done", 32'(done_o), 0);
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_nbytes", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("abort_b0", 32'(got_q[0]), 32'(aw[7:0]));
      chk("abort_b1", 32'(got_q[1]), 32'(aw[15:8]));
    end
    run_dump($urandom_range(0, DEPTH - 1), 2, 1'b0, 1'b0);

    // reset in the middle of SEND
    got_q.delete();
    start_addr_i = 32'($urandom_range(0, DEPTH - 1)) << 2; word_count_i = (AW+1)'(3); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 50 && got_q.size() < 2; k++) begin
      @(posedge clk_i); #1;
    end
    chk("rst_sync", got_q.size(), 2);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_valid", 32'(tx_valid_o), 0);
    chk("midrst_data", 32'(tx_data_o), 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_done", 32'(done_o), 0);
    @(posedge clk_i); #1;
    chk("midrst_busy2", 32'(busy_o), 0);

    for (int t = 0; t < 4; t++)
      run_dump($urandom_range(0, DEPTH - 1), $urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b0);
    run_dump($urandom_range(0, DEPTH - 1), DEPTH, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
